send_pkt_arbiter: RTL and testbench

SEND_PKT_ARBITER -- requirements
Module: send_pkt_arbiter

---
 rtl/send_pkt_arbiter.sv | 140 ++++++++++++++
 tb/tb_send_pkt_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/send_pkt_arbiter.sv
// Round-robin arbiter granting one send buffer at a time
// onto a shared network port, one whole packet per grant.

`ifndef DW
`define DW 16
`endif
`ifndef PKT_LEN
`define PKT_LEN 8
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef TAIL
`define TAIL 2'b10
`endif

module send_pkt_arbiter #(
    parameter int NREQ    = 2,
    parameter int PKT_LEN = `PKT_LEN
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*`DW-1:0]  req_data,
    input  logic [NREQ*8-1:0]    req_cnt,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    output logic [`DW-1:0]       out_data,
    input  logic                 out_ready,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [1:0]  owner;
    logic [1:0]  rr_ptr;
    logic [1:0]  nxt_ptr;
    logic [7:0]  cnt;
    logic        err_q;
    logic [NREQ-1:0] elig;
    logic        pick_found;
    logic [1:0]  pick_idx;
    logic [1:0]  ftype;
    logic        xfer;
    logic        done;
    logic        bad;

    // Eligibility and round-robin search from rr_ptr upward
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i]
                && (req_data[i*`DW+`DW-2 +: 2] == `HEAD)
                && (req_cnt[i*8 +: 8] >= 8'(PKT_LEN));
        end
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!pick_found && elig[idx]) begin
                pick_found = 1'b1;
                pick_idx   = 2'(idx);
            end
        end
    end

    // Transfer qualification and packet framing checks
    always_comb begin
        ftype   = out_data[`DW-1 -: 2];
        xfer    = out_valid && out_ready;
        done    = xfer && (ftype == `TAIL);
        bad     = xfer && (((cnt == 8'(PKT_LEN - 1))
                             && (ftype != `TAIL))
                        || ((ftype == `HEAD) && (cnt != 8'd0)));
        nxt_ptr = (owner == 2'(NREQ - 1)) ? 2'd0 : owner + 2'd1;
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state: grant on any eligible requester, release on TAIL or error
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (pick_found) state_n = SEND;
            SEND: if (done || bad) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Owner, round-robin pointer, flit counter and sticky error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (pick_found) begin
                    owner <= pick_idx;
                    cnt   <= '0;
                end
            end else begin
                if (xfer) cnt <= cnt + 8'd1;
                if (done || bad) rr_ptr <= nxt_ptr;
            end
            if (bad) err_q <= 1'b1;
        end
    end

    // Outputs: the owner's buffer is routed straight to the port
    always_comb begin
        grant     = '0;
        req_ready = '0;
        out_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if ((state == SEND) && (owner == 2'(i))) begin
                grant[i]     = 1'b1;
                req_ready[i] = out_ready;
                out_data     = req_data[i*`DW +: `DW];
            end
        end
        out_valid = |(grant & req_valid);
        busy      = (state == SEND);
        err       = err_q;
    end

endmodule

// File: tb/tb_send_pkt_arbiter.sv
// Directed bench for send_pkt_arbiter with NREQ=2, PKT_LEN=8,
// modelling two FWFT send buffers as flit queues.

`timescale 1ns/1ps

module tb_send_pkt_arbiter;

    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [15:0] req_cnt = '0;
    logic [1:0]  req_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b1;
    logic [1:0]  grant;
    logic        busy;
    logic        err;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int          ovr0 = -1;
    int          n_chk = 0;
    int          n_err = 0;
    int          xfer_cnt = 0;
    logic [1:0]  pops;

    send_pkt_arbiter #(.NREQ(2), .PKT_LEN(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_cnt   (req_cnt),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got,
                       logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic drive();
        req_valid[0]   = (q0.size() != 0);
        req_valid[1]   = (q1.size() != 0);
        req_data[15:0] = (q0.size() != 0) ? q0[0] : 16'h0;
        req_data[31:16] = (q1.size() != 0) ? q1[0] : 16'h0;
        req_cnt[7:0]   = (ovr0 >= 0) ? 8'(ovr0) : 8'(q0.size());
        req_cnt[15:8]  = 8'(q1.size());
    endtask

    function automatic logic [15:0] mk(logic [1:0] t, int r,
                                       int p, int k);
        return {t, 4'(r), 4'(p), 6'(k)};
    endfunction

    task automatic push(int r, int p, bit malformed);
        logic [1:0] t;
        for (int k = 0; k < 8; k++) begin
            t = (k == 0) ? T_HEAD :
                (k == 7) ? (malformed ? T_BODY : T_TAIL) : T_BODY;
            if (r == 0) q0.push_back(mk(t, r, p, k));
            else        q1.push_back(mk(t, r, p, k));
        end
        drive();
    endtask

    // One clock: starts and ends at a falling edge
    task automatic cyc();
        #1;
        pops = req_ready & req_valid;
        if (out_valid && out_ready) xfer_cnt++;
        @(posedge clk);
        #1;
        if (pops[0]) void'(q0.pop_front());
        if (pops[1]) void'(q1.pop_front());
        drive();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        q0.delete();
        q1.delete();
        ovr0 = -1;
        out_ready = 1'b1;
        drive();
        cyc();
        cyc();
        rstn = 1'b1;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (grant == 2'b00 && n < 40) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            cyc();
            n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int c;
        logic [15:0] prev;
        logic [1:0]  exp_g;

        @(negedge clk);
        drive();
        cyc();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rstn = 1'b1;

        // no eligible requester: stay idle
        cyc();
        cyc();
        chk("idle_no_req", 32'(busy), 32'd0);

        // single contention-free packet
        push(0, 0, 1'b0);
        cyc();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_head", 32'(out_data), 32'h4000);
        xfer_cnt = 0;
        c = 0;
        while (busy && c < 40) begin
            cyc();
            c++;
        end
        chk("t1_xfers", 32'(xfer_cnt), 32'd8);
        chk("t1_cycles", 32'(c), 32'd8);
        chk("t1_idle_grant", 32'(grant), 32'd0);
        chk("t1_idle_data", 32'(out_data), 32'd0);
        push(0, 1, 1'b0);
        push(1, 0, 1'b0);
        cyc();
        chk("t1_rr_ptr", 32'(grant), 32'h2);

        // fairness from reset
        do_reset();
        push(0, 0, 1'b0);
        push(0, 1, 1'b0);
        push(1, 0, 1'b0);
        push(1, 1, 1'b0);
        for (int p = 0; p < 4; p++) begin
            exp_g = (p % 2 == 0) ? 2'b01 : 2'b10;
            wait_grant(n);
            chk("fair_grant", 32'(grant), 32'(exp_g));
            chk("fair_latency", 32'(n), 32'd1);
            xfer_cnt = 0;
            wait_idle();
            chk("fair_len", 32'(xfer_cnt), 32'd8);
        end

        // threshold: req 0 short of a packet
        do_reset();
        ovr0 = 7;
        push(0, 0, 1'b0);
        push(1, 0, 1'b0);
        wait_grant(n);
        chk("thr_grant1", 32'(grant), 32'h2);
        ovr0 = -1;
        drive();
        wait_idle();
        wait_grant(n);
        chk("thr_grant0", 32'(grant), 32'h1);
        chk("thr_bubble", 32'(n), 32'd1);
        wait_idle();

        // backpressure: ready alternates 1,0
        do_reset();
        push(0, 2, 1'b0);
        wait_grant(n);
        xfer_cnt = 0;
        c = 0;
        while (busy && c < 40) begin
            out_ready = (c % 2 == 0);
            prev = out_data;
            cyc();
            c++;
            if (c % 2 == 0) begin
                chk("bp_data", 32'(out_data), 32'(prev));
                chk("bp_grant", 32'(grant), 32'h1);
            end
        end
        out_ready = 1'b1;
        chk("bp_cycles", 32'(c), 32'd15);
        chk("bp_xfers", 32'(xfer_cnt), 32'd8);

        // malformed packet: last flit not TAIL
        do_reset();
        push(0, 3, 1'b1);
        push(1, 3, 1'b0);
        wait_grant(n);
        chk("bad_grant0", 32'(grant), 32'h1);
        xfer_cnt = 0;
        wait_idle();
        chk("bad_xfers", 32'(xfer_cnt), 32'd8);
        chk("bad_err", 32'(err), 32'd1);
        wait_grant(n);
        chk("bad_next", 32'(grant), 32'h2);
        wait_idle();
        chk("bad_sticky", 32'(err), 32'd1);
        rstn = 1'b0;
        #1;
        chk("bad_clear", 32'(err), 32'd0);

        // reset mid-packet
        do_reset();
        push(0, 4, 1'b0);
        push(1, 4, 1'b0);
        wait_grant(n);
        xfer_cnt = 0;
        for (int i = 0; i < 4; i++) cyc();
        #1;
        chk("mid_xfers", 32'(xfer_cnt), 32'd4);
        rstn = 1'b0;
        #1;
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_grant", 32'(grant), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ready", 32'(req_ready), 32'd0);
        chk("mid_data", 32'(out_data), 32'd0);
        @(negedge clk);
        do_reset();
        push(0, 5, 1'b0);
        push(1, 5, 1'b0);
        wait_grant(n);
        chk("mid_regrant", 32'(grant), 32'h1);
        chk("mid_regrant_head", 32'(out_data), 32'h4140);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
